ethernet_fmc_reg_master: RTL and testbench

ETHERNET_FMC_REG_MASTER -- requirements
Module: ethernet_fmc_reg_master

---
 rtl/ethernet_fmc_reg_master.sv | 132 +++++++++++++
 tb/tb_ethernet_fmc_reg_master.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ethernet_fmc_reg_master.sv
// Single-outstanding command-to-config-register bridge: accepts one read/write request,
// drives a one-cycle config strobe, waits out the read latency and holds the response.
module ethernet_fmc_reg_master #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned BSEL_W     = 8,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  input  logic [BSEL_W-1:0] req_bsel_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [DATA_W-1:0] resp_rdata_o,
  output logic              resp_write_o,
  output logic              resp_err_o,
  output logic              config_en_o,
  output logic [BSEL_W-1:0] config_wben_o,
  output logic [ADDR_W-1:0] config_addr_o,
  output logic [DATA_W-1:0] config_wdata_o,
  input  logic [DATA_W-1:0] config_rdata_i,
  output logic [31:0]       txn_count_o
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  localparam logic [3:0] RdLatCnt = 4'(RD_LATENCY);

  state_e              state_q;
  logic [3:0]          cnt_q;
  logic                write_q;
  logic                req_ready_q;
  logic                config_en_q;
  logic [BSEL_W-1:0]   config_wben_q;
  logic [ADDR_W-1:0]   config_addr_q;
  logic [DATA_W-1:0]   config_wdata_q;
  logic                resp_valid_q;
  logic [DATA_W-1:0]   resp_rdata_q;
  logic                resp_write_q;
  logic                resp_err_q;
  logic [31:0]         txn_count_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      write_q        <= 1'b0;
      req_ready_q    <= 1'b0;
      config_en_q    <= 1'b0;
      config_wben_q  <= '0;
      config_addr_q  <= '0;
      config_wdata_q <= '0;
      resp_valid_q   <= 1'b0;
      resp_rdata_q   <= '0;
      resp_write_q   <= 1'b0;
      resp_err_q     <= 1'b0;
      txn_count_q    <= '0;
    end else begin
      // The strobe and byte enables are only ever live for the single ISSUE cycle.
      config_en_q   <= 1'b0;
      config_wben_q <= '0;
      case (state_q)
        StIdle: begin
          req_ready_q <= 1'b1;
          if (req_valid_i && req_ready_q) begin
            req_ready_q    <= 1'b0;
            write_q        <= req_write_i;
            config_addr_q  <= req_addr_i;
            config_wdata_q <= req_wdata_i;
            resp_write_q   <= req_write_i;
            resp_rdata_q   <= '0;
            if (req_write_i && (req_bsel_i == '0)) begin
              // A write that touches no bytes is refused without touching the bus.
              resp_err_q   <= 1'b1;
              resp_valid_q <= 1'b1;
              state_q      <= StResp;
            end else begin
              resp_err_q    <= 1'b0;
              config_en_q   <= 1'b1;
              config_wben_q <= req_write_i ? req_bsel_i : '0;
              state_q       <= StIssue;
            end
          end
        end
        StIssue: begin
          if (write_q) begin
            resp_valid_q <= 1'b1;
            state_q      <= StResp;
          end else begin
            cnt_q   <= RdLatCnt;
            state_q <= StWait;
          end
        end
        StWait: begin
          if (cnt_q == 4'd1) begin
            resp_rdata_q <= config_rdata_i;
            resp_valid_q <= 1'b1;
            state_q      <= StResp;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp: begin
          if (resp_ready_i) begin
            resp_valid_q <= 1'b0;
            txn_count_q  <= txn_count_q + 32'd1;
            req_ready_q  <= 1'b1;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready_o    = req_ready_q;
  assign config_en_o    = config_en_q;
  assign config_wben_o  = config_wben_q;
  assign config_addr_o  = config_addr_q;
  assign config_wdata_o = config_wdata_q;
  assign resp_valid_o   = resp_valid_q;
  assign resp_rdata_o   = resp_rdata_q;
  assign resp_write_o   = resp_write_q;
  assign resp_err_o     = resp_err_q;
  assign txn_count_o    = txn_count_q;

endmodule

// File: tb/tb_ethernet_fmc_reg_master.sv
// Scoreboard bench: two instances (read latency 1 and 3) share the command stream;
// a negedge monitor pops expected responses per instance and checks payload and timing.
module tb_ethernet_fmc_reg_master;

  typedef struct {
    logic        write;
    logic        err;
    logic [63:0] rdata;
    int          lat;
    int          en;
    logic [7:0]  wben;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [31:0] txn;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [7:0]  req_bsel = '0;
  logic        resp_ready = 1'b1;

  logic        req_ready   [2];
  logic        resp_valid  [2];
  logic [63:0] resp_rdata  [2];
  logic        resp_write  [2];
  logic        resp_err    [2];
  logic        config_en   [2];
  logic [7:0]  config_wben [2];
  logic [31:0] config_addr [2];
  logic [63:0] config_wdata[2];
  logic [63:0] config_rdata[2];
  logic [31:0] txn_count   [2];

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          nexp = 0;
  int          acc [2] = '{0, 0};
  int          en_cnt [2] = '{0, 0};
  int          en_cyc [2] = '{-100, -100};
  logic [7:0]  en_wben [2];
  logic [31:0] en_addr [2];
  logic [63:0] en_wdata [2];
  bit          vis [2] = '{0, 0};
  exp_t        sb [2][$];
  exp_t        e;
  localparam int Lat [2] = '{1, 3};

  always #5 clk = ~clk;

  ethernet_fmc_reg_master #(.ADDR_W(32), .DATA_W(64), .BSEL_W(8), .RD_LATENCY(1)) u_dut0 (
    .clk_i(clk), .reset_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready[0]),
    .req_write_i(req_write), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_bsel_i(req_bsel), .resp_valid_o(resp_valid[0]), .resp_ready_i(resp_ready),
    .resp_rdata_o(resp_rdata[0]), .resp_write_o(resp_write[0]), .resp_err_o(resp_err[0]),
    .config_en_o(config_en[0]), .config_wben_o(config_wben[0]),
    .config_addr_o(config_addr[0]), .config_wdata_o(config_wdata[0]),
    .config_rdata_i(config_rdata[0]), .txn_count_o(txn_count[0])
  );

  ethernet_fmc_reg_master #(.ADDR_W(32), .DATA_W(64), .BSEL_W(8), .RD_LATENCY(3)) u_dut1 (
    .clk_i(clk), .reset_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready[1]),
    .req_write_i(req_write), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_bsel_i(req_bsel), .resp_valid_o(resp_valid[1]), .resp_ready_i(resp_ready),
    .resp_rdata_o(resp_rdata[1]), .resp_write_o(resp_write[1]), .resp_err_o(resp_err[1]),
    .config_en_o(config_en[1]), .config_wben_o(config_wben[1]),
    .config_addr_o(config_addr[1]), .config_wdata_o(config_wdata[1]),
    .config_rdata_i(config_rdata[1]), .txn_count_o(txn_count[1])
  );

  function automatic logic [63:0] good(input logic [31:0] a);
    if (a == 32'h30) return 64'hDEAD;
    return 64'h5A5A_0000_0000_0000 | {32'h0, a};
  endfunction

  // Responder: real data only in the cycle exactly RD_LATENCY after the strobe.
  always_comb begin
    for (int d = 0; d < 2; d++) begin
      config_rdata[d] = 64'hBAD0_0000_0000_0000 | 64'(unsigned'(cyc));
      if (cyc == en_cyc[d] + Lat[d]) config_rdata[d] = good(en_addr[d]);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int d = 0; d < 2; d++) begin
      if (!rst && req_valid && req_ready[d]) begin
        acc[d]    <= cyc;
        en_cnt[d] <= 0;
      end
      if (!rst && config_en[d]) begin
        en_cnt[d]   <= en_cnt[d] + 1;
        en_cyc[d]   <= cyc;
        en_wben[d]  <= config_wben[d];
        en_addr[d]  <= config_addr[d];
        en_wdata[d] <= config_wdata[d];
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst || !resp_valid[d]) begin
        vis[d] = 1'b0;
      end else if (sb[d].size() == 0) begin
        tests++;
        fails++;
        $display("FAIL dut%0d_unexpected_resp: got resp_valid 1 expected 0", d);
      end else begin
        e = sb[d][0];
        chk($sformatf("dut%0d_write", d), 64'(resp_write[d]), 64'(e.write));
        chk($sformatf("dut%0d_err", d), 64'(resp_err[d]), 64'(e.err));
        chk($sformatf("dut%0d_rdata", d), resp_rdata[d], e.rdata);
        chk($sformatf("dut%0d_req_ready_busy", d), 64'(req_ready[d]), 64'h0);
        if (!vis[d]) begin
          vis[d] = 1'b1;
          chk($sformatf("dut%0d_latency", d), 64'(cyc - acc[d]), 64'(e.lat));
          chk($sformatf("dut%0d_en_count", d), 64'(en_cnt[d]), 64'(e.en));
          if (e.en == 1) begin
            chk($sformatf("dut%0d_en_cycle", d), 64'(en_cyc[d] - acc[d]), 64'd1);
            chk($sformatf("dut%0d_wben", d), 64'(en_wben[d]), 64'(e.wben));
            chk($sformatf("dut%0d_cfg_addr", d), 64'(en_addr[d]), 64'(e.addr));
            chk($sformatf("dut%0d_cfg_wdata", d), en_wdata[d], e.wdata);
          end
        end
        if (resp_ready) begin
          chk($sformatf("dut%0d_txn_before", d), 64'(txn_count[d]), 64'(e.txn));
          void'(sb[d].pop_front());
          vis[d] = 1'b0;
        end
      end
    end
  end

  function automatic exp_t mk(input logic w, input logic er, input logic [63:0] rd,
                              input int lat, input int en, input logic [7:0] wb,
                              input logic [31:0] a, input logic [63:0] wd);
    exp_t x;
    x.write = w; x.err = er; x.rdata = rd; x.lat = lat; x.en = en;
    x.wben = wb; x.addr = a; x.wdata = wd; x.txn = 32'(nexp);
    return x;
  endfunction

  task automatic issue(input logic w, input logic [31:0] a, input logic [63:0] wd,
                       input logic [7:0] bs, input exp_t e0, input exp_t e1);
    int k = 0;
    sb[0].push_back(e0);
    sb[1].push_back(e1);
    nexp++;
    req_write = w; req_addr = a; req_wdata = wd; req_bsel = bs; req_valid = 1'b1;
    while (!(req_ready[0] && req_ready[1]) && k < 50) begin
      @(posedge clk); #1; k++;
    end
    if (k >= 50) begin
      tests++; fails++;
      $display("FAIL accept_timeout: got no req_ready expected req_ready 1");
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int k = 0;
    while ((sb[0].size() != 0 || sb[1].size() != 0) && k < 100) begin
      @(posedge clk); #1; k++;
    end
    if (k >= 100) begin
      tests++; fails++;
      $display("FAIL resp_timeout: got %0d/%0d pending expected 0", sb[0].size(), sb[1].size());
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_dut%0d_ready", tag, d), 64'(req_ready[d]), 64'h0);
      chk($sformatf("%s_dut%0d_resp_valid", tag, d), 64'(resp_valid[d]), 64'h0);
      chk($sformatf("%s_dut%0d_config_en", tag, d), 64'(config_en[d]), 64'h0);
      chk($sformatf("%s_dut%0d_txn", tag, d), 64'(txn_count[d]), 64'h0);
      chk($sformatf("%s_dut%0d_rdata", tag, d), resp_rdata[d], 64'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t x0, x1;
    repeat (2) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) chk($sformatf("post_reset_ready%0d", d), 64'(req_ready[d]), 64'h1);

    // Plain write
    x0 = mk(1'b1, 1'b0, 64'h0, 2, 1, 8'h01, 32'h08, 64'h1);
    issue(1'b1, 32'h08, 64'h1, 8'h01, x0, x0);
    wait_done();
    for (int d = 0; d < 2; d++) chk($sformatf("txn_after_write%0d", d), 64'(txn_count[d]), 64'd1);

    // Read: latency 1 vs 3, only the on-time responder value may be captured
    x0 = mk(1'b0, 1'b0, 64'hDEAD, 3, 1, 8'h00, 32'h30, 64'h1);
    x1 = mk(1'b0, 1'b0, 64'hDEAD, 5, 1, 8'h00, 32'h30, 64'h1);
    issue(1'b0, 32'h30, 64'h1, 8'hFF, x0, x1);
    wait_done();

    // Zero byte-select write is an error with no strobe
    x0 = mk(1'b1, 1'b1, 64'h0, 1, 0, 8'h00, 32'h0, 64'h0);
    issue(1'b1, 32'h0C, 64'h77, 8'h00, x0, x0);
    wait_done();

    // Response back-pressure with an ignored competing request
    resp_ready = 1'b0;
    x0 = mk(1'b0, 1'b0, 64'h5A5A_0000_0000_0044, 3, 1, 8'h00, 32'h44, 64'h55);
    x1 = mk(1'b0, 1'b0, 64'h5A5A_0000_0000_0044, 5, 1, 8'h00, 32'h44, 64'h55);
    issue(1'b0, 32'h44, 64'h55, 8'h0F, x0, x1);
    repeat (3) @(posedge clk);
    #1;
    req_write = 1'b1; req_addr = 32'h99; req_wdata = 64'hFFFF; req_bsel = 8'hFF;
    req_valid = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    req_valid = 1'b0;
    resp_ready = 1'b1;
    wait_done();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("stall_no_extra_en%0d", d), 64'(en_cnt[d]), 64'd1);
      chk($sformatf("txn_after_stall%0d", d), 64'(txn_count[d]), 64'd4);
    end

    // Reset while both instances are waiting on read data
    x0 = mk(1'b0, 1'b0, 64'hDEAD, 3, 1, 8'h00, 32'h30, 64'h55);
    issue(1'b0, 32'h30, 64'h55, 8'h00, x0, x0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    sb[0].delete();
    sb[1].delete();
    nexp = 0;
    chk_idle_outputs("mid_reset");
    rst = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("quiet_en%0d", d), 64'(config_en[d]), 64'h0);
        chk($sformatf("quiet_valid%0d", d), 64'(resp_valid[d]), 64'h0);
      end
    end
    for (int d = 0; d < 2; d++) chk($sformatf("recover_ready%0d", d), 64'(req_ready[d]), 64'h1);

    // Recovery write after reset
    x0 = mk(1'b1, 1'b0, 64'h0, 2, 1, 8'hF0, 32'h10, 64'h1234);
    issue(1'b1, 32'h10, 64'h1234, 8'hF0, x0, x0);
    wait_done();
    for (int d = 0; d < 2; d++) chk($sformatf("txn_final%0d", d), 64'(txn_count[d]), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
